// File: rtl/uart_transmitter.sv
// 8N1 UART serializer: one byte per valid/ready handshake. The start bit is on the line at the acceptance edge.
// ready_out stays low for the whole frame; a valid_in seen while busy is dropped and is never queued.
module uart_transmitter #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 3_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       valid_in,
  input  logic [7:0] byte_in,
  output logic       uart_tx_out,
  output logic       ready_out
);

  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (BAUD_BIT_PERIOD > 2) ? $clog2(BAUD_BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_BIT_PERIOD - 1);

  generate
    if (BAUD_BIT_PERIOD < 2) begin : g_bad_period
      $error("uart_transmitter: BAUD_BIT_PERIOD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift_reg, shift_reg_nxt;
  logic             tx_nxt, ready_nxt;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      uart_tx_out <= 1'b1;
      ready_out   <= 1'b1;
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_reg   <= shift_reg_nxt;
      uart_tx_out <= tx_nxt;
      ready_out   <= ready_nxt;
    end
  end

  // The line value is computed one edge ahead, so the output register only moves on bit boundaries.
  always_comb begin
    state_nxt     = state;
    baud_cnt_nxt  = baud_cnt;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    tx_nxt        = uart_tx_out;
    ready_nxt     = ready_out;

    if (state != IDLE) begin
      baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
        if (valid_in && ready_out) begin
          shift_reg_nxt = byte_in;
          tx_nxt        = 1'b0;
          ready_nxt     = 1'b0;
          baud_cnt_nxt  = '0;
          state_nxt     = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = shift_reg[bit_idx_nxt];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          tx_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default instance for framing, timing, busy and reset behaviour,
// plus a short-period instance that sweeps every byte value.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int P  = 33;  // 100 MHz / 3 Mbaud
  localparam int PF = 4;   // 100 MHz / 25 Mbaud

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       valid_in, valid_f;
  logic [7:0] byte_in, byte_f;
  logic       tx, rdy, tx_f, rdy_f;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  uart_transmitter dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .byte_in    (byte_in),
    .uart_tx_out(tx),
    .ready_out  (rdy)
  );

  uart_transmitter #(
    .INPUT_CLOCK_FREQ(100_000_000),
    .BAUD_RATE       (25_000_000)
  ) dut_fast (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_f),
    .byte_in    (byte_f),
    .uart_tx_out(tx_f),
    .ready_out  (rdy_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Handshake one byte; returns 1 ns after the acceptance edge.
  task automatic accept(input logic fast, input logic [7:0] b);
    int waited = 0;
    @(negedge clk_in);
    while (!(fast ? rdy_f : rdy) && waited < 1000) begin
      @(negedge clk_in);
      waited++;
    end
    if (waited >= 1000) begin
      check("rdy_timeout", 32'd0, 32'd1);
      return;
    end
    if (fast) begin valid_f = 1'b1; byte_f = b; end
    else begin valid_in = 1'b1; byte_in = b; end
    @(posedge clk_in);
    #1;
    valid_f  = 1'b0;
    valid_in = 1'b0;
  endtask

  // Sample every falling edge of a frame: bit values at bit starts, glitches inside bits, ready-low cycles.
  task automatic capture(input logic fast, input int inject, output logic [9:0] frame,
                         output int low_cnt, output int glitch);
    int   p;
    int   k;
    logic t, r;
    p = fast ? PF : P;
    frame   = '0;
    low_cnt = 0;
    glitch  = 0;
    for (int n = 0; n <= 10 * p; n++) begin
      @(negedge clk_in);
      if (n == inject) begin
        valid_in = 1'b1;
        byte_in  = 8'hFF;
      end else if (inject >= 0 && n == inject + 1) begin
        valid_in = 1'b0;
      end
      t = fast ? tx_f : tx;
      r = fast ? rdy_f : rdy;
      if (n < 10 * p) begin
        k = n / p;
        if (n % p == 0) frame[k] = t;
        else if (t !== frame[k]) glitch++;
      end
      if (!r) low_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    int         lc, gl, cnt, bad;
    bit         exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    rst_in = 1'b1; valid_in = 1'b0; valid_f = 1'b0; byte_in = '0; byte_f = '0;
    @(posedge clk_in);
    #1;
    check("rst_tx", tx, 1);
    check("rst_rdy", rdy, 1);
    check("rst_tx_fast", tx_f, 1);
    rst_in = 1'b0;

    cnt = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (!tx || !rdy) cnt++;
    end
    check("idle_quiet", cnt, 0);

    // Single byte 0xA5
    accept(1'b0, 8'hA5);
    check("a5_rdy_drop", rdy, 0);
    capture(1'b0, -1, fr, lc, gl);
    for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), fr[k], exp_a5[k]);
    check("a5_rdy_low_cycles", lc, 330);
    check("a5_glitch", gl, 0);

    // Every byte value on the short-period instance
    bad = 0;
    for (int b = 0; b < 256; b++) begin
      accept(1'b1, 8'(b));
      capture(1'b1, -1, fr, lc, gl);
      check($sformatf("exh_frame_%02h", b), fr, {1'b1, 8'(b), 1'b0});
      if (gl != 0 || lc != 10 * PF) bad++;
      repeat (100) @(negedge clk_in);
    end
    check("exh_timing", bad, 0);

    // Busy ignore: 0xFF offered at cycle 100 of a 0x3C frame
    accept(1'b0, 8'h3C);
    capture(1'b0, 100, fr, lc, gl);
    check("busy_frame", fr, {1'b1, 8'h3C, 1'b0});
    check("busy_rdy_low_cycles", lc, 330);
    check("busy_glitch", gl, 0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (!tx || !rdy) cnt++;
    end
    check("busy_no_refire", cnt, 0);

    // Reset at cycle 150 of a 0x00 frame
    accept(1'b0, 8'h00);
    repeat (149) @(posedge clk_in);
    #1;
    check("pre_rst_tx", tx, 0);
    check("pre_rst_rdy", rdy, 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_rdy", rdy, 1);
    rst_in = 1'b0;
    repeat (5) @(posedge clk_in);
    accept(1'b0, 8'h81);
    capture(1'b0, -1, fr, lc, gl);
    check("post_rst_frame", fr, {1'b1, 8'h81, 1'b0});
    check("post_rst_rdy_low_cycles", lc, 330);

    // Back-to-back with valid_in held high
    @(negedge clk_in);
    valid_in = 1'b1;
    byte_in  = 8'h55;
    @(posedge clk_in);
    #1;
    byte_in = 8'hAA;
    check("b2b_rdy_drop1", rdy, 0);
    capture(1'b0, -1, fr, lc, gl);
    check("b2b_frame1", fr, {1'b1, 8'h55, 1'b0});
    check("b2b_gap_tx", tx, 1);
    check("b2b_gap_rdy", rdy, 1);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    check("b2b_rdy_drop2", rdy, 0);
    check("b2b_start2", tx, 0);
    capture(1'b0, -1, fr, lc, gl);
    check("b2b_frame2", fr, {1'b1, 8'hAA, 1'b0});
    check("b2b_glitch2", gl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

8N1 UART serializer. Accepts one byte per valid/ready handshake and shifts it out on a single serial line: start bit, 8 data bits LSB first, one stop bit, each bit held for a fixed number of clock cycles. It sits between a byte-producing host on the system clock and the board TX pin. The line idles high.

## Interface
- `INPUT_CLOCK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 3_000_000: serial bit rate.
- Derived `BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE` (integer division), which is 33 at the defaults. Must be ≥ 2.
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `rst_in`  input  1  reset; synchronous, active-high.
- `valid_in`  input  1  byte_in holds a byte to send.
- `byte_in`  input  8  data byte; sampled only on acceptance.
- `uart_tx_out`  output  1  serial line (registered).
- `ready_out`  output  1  high when a new byte can be accepted (registered).

## Operation
- Reset (rst_in high at a rising edge): `uart_tx_out`=1, `ready_out`=1, FSM=IDLE, counters=0. Reset overrides everything, including a frame in flight; the line returns high on that same edge and the partial frame is dropped.
- Acceptance happens at a rising edge where `valid_in && ready_out` and the block is not in reset. On that edge:
  - latch `byte_in` into the shift register;
  - drive `uart_tx_out`=0 (start bit);
  - drive `ready_out`=0;
  - clear the baud counter;
  - enter START.
- `valid_in` while `ready_out`=0 is ignored. It is not queued, and `byte_in` changes mid-frame have no effect.
- FSM states:
  - IDLE: line=1, ready=1.
  - START: line=0 for `BAUD_BIT_PERIOD` cycles, then go to DATA with bit index 0.
  - DATA: line=data[bit index], LSB first, each bit for `BAUD_BIT_PERIOD` cycles. After bit 7 completes, go to STOP.
  - STOP: line=1 for `BAUD_BIT_PERIOD` cycles, then go to IDLE and set ready=1.
- Baud counter counts 0..`BAUD_BIT_PERIOD`-1 and wraps at the end of each bit period, which advances the bit. Bit index is 3 bits (0..7).
- `uart_tx_out` never glitches: it changes only on bit boundaries.

## Timing
- Let A be the acceptance edge. Bit k (k=0 is start, 1..8 are data[0..7], 9 is stop) is driven on `uart_tx_out` from edge A+k·`BAUD_BIT_PERIOD` until edge A+(k+1)·`BAUD_BIT_PERIOD`.
- Latency from acceptance to start bit on the line is 0 cycles, since the output register updates on edge A.
- Frame length is 10·`BAUD_BIT_PERIOD` cycles (330 at defaults).
- `ready_out` is low from edge A and returns high on edge A+10·`BAUD_BIT_PERIOD`. The earliest next acceptance is one edge later. The stop bit is always transmitted in full.
- `valid_in` held high continuously produces back-to-back frames separated by one idle-high cycle.

## Test plan
- Reset: hold rst_in 1 cycle -> `uart_tx_out`=1, `ready_out`=1. No activity with `valid_in`=0.
- Single byte 0xA5: pulse `valid_in` for 1 cycle. Sampling 5 ns after the acceptance edge and every 330 ns thereafter gives 0,1,0,1,0,0,1,0,1,1. `ready_out` is low for exactly 330 cycles.
- Exhaustive 0x00–0xFF: each byte pulsed with ≥1000 ns idle gaps. Sampled bits [8:1] equal the byte, start=0, stop=1 for all 256.
- Busy ignore: send 0x3C, then assert `valid_in` with 0xFF at cycle 100 of the frame. The frame still carries 0x3C and no second frame starts.
- Reset mid-frame: send 0x00 and assert rst_in at cycle 150. The line goes 1 on that edge, `ready_out`=1, and a following byte 0x81 transmits correctly.
- Back-to-back: hold `valid_in`=1 with 0x55, then 0xAA. There is one idle-high cycle between frames and both bytes decode correctly.
